fetch_stage: RTL



---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 86 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: instruction classes, raw opcodes, and the fetch
// buffer entry together with its pre-decode helper.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {R_OP, I_OP, L_OP, S_OP, B_OP, J_OP, JR_OP} opcode_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    opcode_t         op;
    logic            illegal;
  } fetch_entry_t;

  // Unknown opcodes fall back to I_OP so the control unit always sees a legal class.
  function automatic fetch_entry_t predecode(input logic [31:0] instr,
                                             input logic [XLEN-1:0] pc);
    fetch_entry_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.op      = I_OP;
    e.illegal = 1'b0;
    case (instr[6:0])
      OPC_OP:     e.op = R_OP;
      OPC_OP_IMM: e.op = I_OP;
      OPC_LOAD:   e.op = L_OP;
      OPC_STORE:  e.op = S_OP;
      OPC_BRANCH: e.op = B_OP;
      OPC_JAL:    e.op = J_OP;
      OPC_JALR:   e.op = JR_OP;
      default:    e.illegal = 1'b1;
    endcase
    return e;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory handshake, redirect input and decode-side
// output. master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if import riscv_pkg::*; #(parameter int XLEN = 32);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            if_valid_o;
  logic            if_ready_i;
  logic [31:0]     if_instr_o;
  logic [XLEN-1:0] if_pc_o;
  opcode_t         if_op_o;
  logic            if_illegal_o;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_op_o, if_illegal_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, if_ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_op_o, if_illegal_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, if_ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Registered circular buffer of pre-decoded fetch entries; flush empties it
// without touching stored data.
module fetch_fifo import riscv_pkg::*; #(
  parameter int           DEPTH     = 2,
  parameter int           CW        = $clog2(DEPTH + 1),
  parameter fetch_entry_t RST_ENTRY = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= inc(wr_q);
      end
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited in-order word requests, response buffering
// with pre-decode, and redirect handling that drops stale in-flight responses.
module fetch_stage import riscv_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  fetch_stage_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam fetch_entry_t RST_ENTRY = '{instr: NOP, pc: RESET_PC, op: I_OP, illegal: 1'b0};

  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, fifo_cnt;
  logic [SW-1:0]   used;
  logic            credit, req, grant, resp, dropping, push, pop;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    head, wentry;

  assign tgt      = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
  // Credit only looks at registered counts: a same-cycle pop frees nothing yet.
  assign used     = SW'(outst_q) + SW'(fifo_cnt);
  assign credit   = used < SW'(DEPTH);
  assign req      = rst_ni && credit && !bus.redirect_i;
  assign grant    = req && bus.imem_gnt_i;
  assign resp     = bus.imem_rvalid_i;
  assign dropping = (drop_q != '0);
  assign push     = resp && !dropping && !bus.redirect_i && !fifo_full;
  assign pop      = !fifo_empty && bus.if_ready_i;
  assign wentry   = predecode(bus.imem_rdata_i, resp_pc_q);

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    // Stale responses still decrement outstanding, so credit returns as they drain.
    outst_d   = outst_q + CW'(grant) - CW'(resp);
    if (bus.redirect_i) begin
      pc_d      = tgt;
      resp_pc_d = tgt;
      drop_d    = outst_q - CW'(resp);
    end else begin
      if (grant)             pc_d      = pc_q + XLEN'(4);
      if (push)              resp_pc_d = resp_pc_q + XLEN'(4);
      if (resp && dropping)  drop_d    = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW), .RST_ENTRY(RST_ENTRY)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_i),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = pc_q;
  assign bus.if_valid_o   = !fifo_empty;
  assign bus.if_instr_o   = head.instr;
  assign bus.if_pc_o      = head.pc;
  assign bus.if_op_o      = head.op;
  assign bus.if_illegal_o = head.illegal;
endmodule
